// File: rtl/mem_access_sequencer_if.sv
// Requester, shared-bus and MAR/RAM strobe signals of mem_access_sequencer.
// The slave modport is the sequencer's view; the master modport is the CPU/RAM side.
interface mem_access_sequencer_if #(
    parameter int BUS_WIDTH = 16
);
    logic                 req0;
    logic                 we0;
    logic [BUS_WIDTH-1:0] addr0;
    logic [BUS_WIDTH-1:0] wdata0;
    logic                 ack0;
    logic                 req1;
    logic                 we1;
    logic [BUS_WIDTH-1:0] addr1;
    logic [BUS_WIDTH-1:0] wdata1;
    logic                 ack1;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 err;
    logic                 busy;
    logic [BUS_WIDTH-1:0] bus_out;
    logic                 bus_oe;
    logic [BUS_WIDTH-1:0] bus_in;
    logic                 mar_le;
    logic                 mar_oe;
    logic                 ram_oe;
    logic                 ram_we;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_in,
        output ack0, ack1, rdata, err, busy, bus_out, bus_oe, mar_le, mar_oe, ram_oe, ram_we
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, bus_in,
        input  ack0, ack1, rdata, err, busy, bus_out, bus_oe, mar_le, mar_oe, ram_oe, ram_we
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Round-robin two-port MAR/RAM access sequencer; requests are level-held until the one-cycle ack.
// Read ack 2+READ_WAIT cycles after grant cycle, write ack 3 (+READ_WAIT with MEM_SEQ_WRITE_VERIFY_EN).
module mem_access_sequencer #(
    parameter int BUS_WIDTH = 16,
    parameter int READ_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_sequencer_if.slave io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_WAIT_LAST = 4'(READ_WAIT - 1);

    state_t               r_state;
    logic                 r_rr_pri;
    logic                 r_id;
    logic                 r_we;
    logic [BUS_WIDTH-1:0] r_wdata;
    logic [3:0]           r_cnt;
    logic [BUS_WIDTH-1:0] r_rdata;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_err;
    logic                 r_busy;
    logic [BUS_WIDTH-1:0] r_bus_out;
    logic                 r_bus_oe;
    logic                 r_mar_le;
    logic                 r_mar_oe;
    logic                 r_ram_oe;
    logic                 r_ram_we;

    logic                 w_gnt1;
    logic                 w_we;
    logic [BUS_WIDTH-1:0] w_addr;
    logic [BUS_WIDTH-1:0] w_wdata;

    // r_rr_pri names the port that wins the next tie.
    assign w_gnt1  = io_bus.req1 & (~io_bus.req0 | r_rr_pri);
    assign w_we    = w_gnt1 ? io_bus.we1    : io_bus.we0;
    assign w_addr  = w_gnt1 ? io_bus.addr1  : io_bus.addr0;
    assign w_wdata = w_gnt1 ? io_bus.wdata1 : io_bus.wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_pri  <= 1'b0;
            r_id      <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_bus_out <= '0;
            r_bus_oe  <= 1'b0;
            r_mar_le  <= 1'b0;
            r_mar_oe  <= 1'b0;
            r_ram_oe  <= 1'b0;
            r_ram_we  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.req0 || io_bus.req1) begin
                        r_id      <= w_gnt1;
                        r_rr_pri  <= ~w_gnt1;
                        r_we      <= w_we;
                        r_wdata   <= w_wdata;
                        r_bus_out <= w_addr;
                        r_bus_oe  <= 1'b1;
                        r_mar_le  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_mar_le <= 1'b0;
                    r_mar_oe <= 1'b1;
                    if (r_we) begin
                        r_bus_out <= r_wdata;
                        r_ram_we  <= 1'b1;
                        r_state   <= S_WRITE;
                    end else begin
                        r_bus_oe  <= 1'b0;
                        r_bus_out <= '0;
                        r_ram_oe  <= 1'b1;
                        r_cnt     <= LP_WAIT_LAST;
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata  <= io_bus.bus_in;
                        r_ack0   <= ~r_id;
                        r_ack1   <= r_id;
                        r_mar_oe <= 1'b0;
                        r_ram_oe <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    r_bus_oe  <= 1'b0;
                    r_bus_out <= '0;
                    r_ram_we  <= 1'b0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
                    r_ram_oe  <= 1'b1;
                    r_cnt     <= LP_WAIT_LAST;
                    r_state   <= S_VERIFY;
`else
                    r_mar_oe  <= 1'b0;
                    r_ack0    <= ~r_id;
                    r_ack1    <= r_id;
                    r_state   <= S_DONE;
`endif
                end
`ifdef MEM_SEQ_WRITE_VERIFY_EN
                S_VERIFY: begin
                    // Read-back check only; rdata keeps the last real read.
                    if (r_cnt == 4'd0) begin
                        r_err    <= (io_bus.bus_in != r_wdata);
                        r_ack0   <= ~r_id;
                        r_ack1   <= r_id;
                        r_mar_oe <= 1'b0;
                        r_ram_oe <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.ack0    = r_ack0;
    assign io_bus.ack1    = r_ack1;
    assign io_bus.rdata   = r_rdata;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
    assign io_bus.err     = r_err;
`else
    assign io_bus.err     = 1'b0;
`endif
    assign io_bus.busy    = r_busy;
    assign io_bus.bus_out = r_bus_out;
    assign io_bus.bus_oe  = r_bus_oe;
    assign io_bus.mar_le  = r_mar_le;
    assign io_bus.mar_oe  = r_mar_oe;
    assign io_bus.ram_oe  = r_ram_oe;
    assign io_bus.ram_we  = r_ram_we;
endmodule
